// File: rtl/jtyiear_pal_pkg.sv
// Shared types and constants for the Yie Ar palette PROM loader.
// A FIFO entry packs the 5-bit PROM index above the 8-bit data byte.
package jtyiear_pal_pkg;

  localparam int PAL_LEN = 32;
  localparam int FIFO_W  = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } pal_state_t;

  typedef struct packed {
    logic [4:0] idx;
    logic [7:0] data;
  } pal_entry_t;

endpackage

// File: rtl/jtyiear_pal_fifo.sv
// Two-entry FIFO between the download strobe register and the PROM writer.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module jtyiear_pal_fifo
  import jtyiear_pal_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [FIFO_W-1:0] i_din,
  output logic [FIFO_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty
);

  logic [FIFO_W-1:0] r_mem [2];
  logic              r_rd;
  logic              r_wr;
  logic [1:0]        r_cnt;
  logic              w_do_pop;
  logic              w_do_push;

  assign o_full    = (r_cnt == 2'd2);
  assign o_empty   = (r_cnt == 2'd0);
  assign o_dout    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_clr) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= ~r_wr;
      end
      if (w_do_pop) begin
        r_rd <= ~r_rd;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/jtyiear_pal_loader.sv
// Captures the palette PROM image from the ROM download stream and writes it
// to the PROM through a small FIFO, tracking coverage, checksum and errors.
module jtyiear_pal_loader #(
  parameter logic [24:0] PAL_START = 25'h0A000,
  parameter int          PAL_LEN   = jtyiear_pal_pkg::PAL_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic [4:0]  prog_addr,
  output logic [7:0]  prog_data,
  output logic        prog_en,
  output logic        pal_done,
  output logic        pal_err,
  output logic [7:0]  pal_sum
);
  import jtyiear_pal_pkg::*;

  pal_state_t         r_state;
  pal_state_t         w_next;
  logic               r_dl_prev;
  logic               w_dl_rise;
  logic               w_dl_fall;
  logic [24:0]        w_off;
  logic               w_hit;
  logic               r_stb;
  pal_entry_t         r_entry;
  logic [FIFO_W-1:0]  w_dout;
  pal_entry_t         w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic [PAL_LEN-1:0] r_bitmap;
  logic [7:0]         r_sum;
  logic               r_done;
  logic               r_err;

  assign w_dl_rise = downloading && !r_dl_prev;
  assign w_dl_fall = !downloading && r_dl_prev;
  assign w_off     = ioctl_addr - PAL_START;
  assign w_hit     = ioctl_wr && (r_state == LOAD) &&
                     (ioctl_addr >= PAL_START) && (w_off < 25'(PAL_LEN));
  assign w_head    = pal_entry_t'(w_dout);
  assign w_pop     = !w_empty && ((r_state == LOAD) || (r_state == FLUSH));

  // Edge history starts high so a download already in progress at reset is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dl_prev <= 1'b1;
      r_stb     <= 1'b0;
      r_entry   <= '0;
    end else begin
      r_dl_prev <= downloading;
      r_stb     <= w_hit && !w_dl_rise;
      if (w_hit) begin
        r_entry <= '{idx: w_off[4:0], data: ioctl_dout};
      end
    end
  end

  jtyiear_pal_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_dl_rise),
    .i_push  (r_stb),
    .i_pop   (w_pop),
    .i_din   (r_entry),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FLUSH also waits out a byte still sitting in the strobe register.
  always_comb begin
    w_next = r_state;
    if (w_dl_rise) begin
      w_next = LOAD;
    end else begin
      case (r_state)
        LOAD:    if (w_dl_fall) w_next = FLUSH;
        FLUSH:   if (w_empty && !r_stb) w_next = DONE;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitmap <= '0;
      r_sum    <= 8'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_dl_rise) begin
      r_bitmap <= '0;
      r_sum    <= 8'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_bitmap[w_head.idx] <= 1'b1;
        r_sum                <= r_sum + w_head.data;
      end
      if (r_stb && w_full && !w_pop) begin
        r_err <= 1'b1;
      end
      if ((r_state == FLUSH) && (w_next == DONE)) begin
        if (&r_bitmap) r_done <= 1'b1;
        else           r_err  <= 1'b1;
      end
    end
  end

  assign prog_en   = w_pop;
  assign prog_addr = w_pop ? w_head.idx  : 5'd0;
  assign prog_data = w_pop ? w_head.data : 8'd0;
  assign pal_done  = r_done;
  assign pal_err   = r_err;
  assign pal_sum   = r_sum;

endmodule

// File: tb/tb_jtyiear_pal_loader.sv
// Directed bench for the palette loader: each task drives one scenario and
// checks PROM writes, latency, checksum and status against hand-derived values.
module tb_jtyiear_pal_loader;

  localparam logic [24:0] PS = 25'h0A000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [4:0]  prog_addr;
  logic [7:0]  prog_data;
  logic        prog_en;
  logic        pal_done;
  logic        pal_err;
  logic [7:0]  pal_sum;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pulse_cnt = 0;
  int base     = 0;
  logic [4:0] pa [256];
  logic [7:0] pd [256];
  int         pc [256];

  jtyiear_pal_loader #(.PAL_START(PS), .PAL_LEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_en     (prog_en),
    .pal_done    (pal_done),
    .pal_err     (pal_err),
    .pal_sum     (pal_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every PROM write pulse with its cycle number.
  always @(negedge clk) begin
    if (prog_en) begin
      if (pulse_cnt < 256) begin
        pa[pulse_cnt] = prog_addr;
        pd[pulse_cnt] = prog_data;
        pc[pulse_cnt] = cyc;
      end
      pulse_cnt = pulse_cnt + 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [24:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    downloading = 1'b0;
    tick();
    downloading = 1'b1;
    tick();
    base = pulse_cnt;
  endtask

  task automatic end_dl();
    downloading = 1'b0;
    tick(8);
  endtask

  task automatic check_status(input string name, input logic [7:0] exp_sum,
                              input logic exp_done, input logic exp_err, input int exp_pulses);
    n_checks++;
    if (pal_sum !== exp_sum) $display("[TB] FAIL %s pal_sum: got %h expected %h", name, pal_sum, exp_sum);
    else n_pass++;
    n_checks++;
    if (pal_done !== exp_done) $display("[TB] FAIL %s pal_done: got %b expected %b", name, pal_done, exp_done);
    else n_pass++;
    n_checks++;
    if (pal_err !== exp_err) $display("[TB] FAIL %s pal_err: got %b expected %b", name, pal_err, exp_err);
    else n_pass++;
    n_checks++;
    if (pulse_cnt - base !== exp_pulses)
      $display("[TB] FAIL %s pulses: got %0d expected %0d", name, pulse_cnt - base, exp_pulses);
    else n_pass++;
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if ({prog_en, prog_addr, prog_data, pal_done, pal_err, pal_sum} !== 24'd0)
      $display("[TB] FAIL %s outputs: got en=%b addr=%h data=%h done=%b err=%b sum=%h expected all 0",
               name, prog_en, prog_addr, prog_data, pal_done, pal_err, pal_sum);
    else n_pass++;
  endtask

  task automatic check_sequence(input string name, input int count);
    for (int i = 0; i < count; i++) begin
      n_checks++;
      if (pa[base + i] !== 5'(i) || pd[base + i] !== 8'(i))
        $display("[TB] FAIL %s write %0d: got addr=%h data=%h expected addr=%h data=%h",
                 name, i, pa[base + i], pd[base + i], 5'(i), 8'(i));
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #2;
    check_outputs_zero("reset");
    downloading = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(3);
    base = pulse_cnt;
    strobe(PS + 25'd3, 8'h77);
    tick(4);
    n_checks++;
    if (pulse_cnt - base !== 0)
      $display("[TB] FAIL idle_after_reset pulses: got %0d expected 0", pulse_cnt - base);
    else n_pass++;
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_full_image();
    int s0;
    start_dl();
    s0 = cyc;
    for (int i = 0; i < 32; i++) begin
      strobe(PS + 25'(i), 8'(i));
      tick(3);
    end
    n_checks++;
    if (pc[base] !== s0 + 2) $display("[TB] FAIL full latency: got cycle %0d expected %0d", pc[base], s0 + 2);
    else n_pass++;
    end_dl();
    check_sequence("full", 32);
    check_status("full", 8'hF0, 1'b1, 1'b0, 32);
  endtask

  task automatic test_out_of_window();
    start_dl();
    strobe(PS - 25'd1, 8'hAA);
    strobe(PS + 25'd32, 8'h55);
    tick(4);
    n_checks++;
    if (pulse_cnt - base !== 0)
      $display("[TB] FAIL window pulses: got %0d expected 0", pulse_cnt - base);
    else n_pass++;
    end_dl();
    check_status("window", 8'h00, 1'b0, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    int s0;
    start_dl();
    s0 = cyc;
    for (int i = 0; i < 32; i++) begin
      ioctl_addr = PS + 25'(i);
      ioctl_dout = 8'(i);
      ioctl_wr   = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    tick(4);
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (pc[base + i] !== s0 + 2 + i)
        $display("[TB] FAIL b2b timing %0d: got cycle %0d expected %0d", i, pc[base + i], s0 + 2 + i);
      else n_pass++;
    end
    end_dl();
    check_sequence("b2b", 32);
    check_status("b2b", 8'hF0, 1'b1, 1'b0, 32);
  endtask

  task automatic test_late_fall();
    start_dl();
    for (int i = 0; i < 31; i++) begin
      strobe(PS + 25'(i), 8'(i));
      tick();
    end
    strobe(PS + 25'd31, 8'd31);
    downloading = 1'b0;
    tick(8);
    check_sequence("late_fall", 32);
    check_status("late_fall", 8'hF0, 1'b1, 1'b0, 32);
  endtask

  task automatic test_reset_midway();
    start_dl();
    for (int i = 0; i < 10; i++) begin
      strobe(PS + 25'(i), 8'(i) + 8'd1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    start_dl();
    for (int i = 0; i < 32; i++) begin
      strobe(PS + 25'(i), 8'(i) + 8'd3);
      tick();
    end
    end_dl();
    check_status("after_reset", 8'h50, 1'b1, 1'b0, 32);
  endtask

  task automatic test_repeat_index();
    logic [7:0] last5;
    last5 = 8'hXX;
    start_dl();
    for (int i = 0; i < 32; i++) begin
      strobe(PS + 25'(i), (i == 5) ? 8'h10 : 8'(i));
      tick();
    end
    strobe(PS + 25'd5, 8'h20);
    end_dl();
    for (int i = 0; i < pulse_cnt - base; i++) begin
      if (pa[base + i] == 5'd5) last5 = pd[base + i];
    end
    n_checks++;
    if (last5 !== 8'h20) $display("[TB] FAIL repeat last_data5: got %h expected 20", last5);
    else n_pass++;
    check_status("repeat", 8'h1B, 1'b1, 1'b0, 33);
  endtask

  initial begin
    rst_n       = 1'b0;
    downloading = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    ioctl_wr    = 1'b0;
    test_reset();
    test_full_image();
    test_out_of_window();
    test_back_to_back();
    test_late_fall();
    test_reset_midway();
    test_repeat_index();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
